// File: rtl/matrix_host_driver.sv
// Host-side initiator for the matrix processor: loads operand rows, streams them one per cycle, collects 8 result rows.
// Latency start->done is N+10 cycles (18 / 26); no backpressure, the processor must keep pace; a missing first result aborts after TIMEOUT.
module matrix_host_driver #(
    parameter int WIDTH   = 32,
    parameter int ROWS    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] const_in,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             proc_reset,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] constant,
    output logic [WIDTH-1:0] data,
    output logic             data_ready,
    input  logic [WIDTH-1:0] out,
    input  logic             out_valid
);

    localparam int DEPTH = 2 * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int RAW   = $clog2(ROWS);
    localparam int FW    = AW + 1;
    localparam int CW    = RAW + 1;
    localparam int TW    = $clog2(TIMEOUT) + 1;

    localparam logic [FW-1:0] N_LONG   = FW'(DEPTH);
    localparam logic [FW-1:0] N_SHORT  = FW'(ROWS);
    localparam logic [CW-1:0] CAP_LAST = CW'(ROWS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_COLLECT
    } state_t;

    // Zero means the opcode is not accepted by the processor.
    function automatic logic [FW-1:0] row_count(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1111: row_count = N_LONG;
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1110:                            row_count = N_SHORT;
            default:                                     row_count = '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             proc_reset_q, proc_reset_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] constant_q, constant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             data_ready_q, data_ready_d;
    logic [FW-1:0]    n_q, n_d;
    logic [FW-1:0]    feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]    cap_cnt_q, cap_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [WIDTH-1:0] opd_q [DEPTH];
    logic [WIDTH-1:0] opd_d [DEPTH];
    logic [WIDTH-1:0] res_q [ROWS];
    logic [WIDTH-1:0] res_d [ROWS];
    logic [FW-1:0]    req_n;

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        proc_reset_d = proc_reset_q;
        opcode_d     = opcode_q;
        constant_d   = constant_q;
        data_d       = data_q;
        data_ready_d = data_ready_q;
        n_d          = n_q;
        feed_cnt_d   = feed_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        opd_d        = opd_q;
        res_d        = res_q;
        req_n        = row_count(op_in);

        case (state_q)
            S_IDLE: begin
                proc_reset_d = 1'b0;
                if (wr_en) begin
                    opd_d[wr_addr] = wr_data;
                end
                if (start) begin
                    if (req_n == '0) begin
                        err_d = 1'b1;
                    end else begin
                        opcode_d     = op_in;
                        constant_d   = const_in;
                        n_d          = req_n;
                        proc_reset_d = 1'b1;
                        state_d      = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                proc_reset_d = 1'b0;
                data_ready_d = 1'b1;
                data_d       = opd_q[0];
                feed_cnt_d   = FW'(1);
                state_d      = S_FEED;
            end
            S_FEED: begin
                // feed_cnt reaching N means row N-1 has just had its cycle on the bus.
                if (feed_cnt_q == n_q) begin
                    data_ready_d = 1'b0;
                    data_d       = '0;
                    cap_cnt_d    = '0;
                    tmo_cnt_d    = '0;
                    state_d      = S_COLLECT;
                end else begin
                    data_d     = opd_q[feed_cnt_q[AW-1:0]];
                    feed_cnt_d = feed_cnt_q + 1'b1;
                end
            end
            S_COLLECT: begin
                if (out_valid && (cap_cnt_q <= CAP_LAST)) begin
                    res_d[cap_cnt_q[RAW-1:0]] = out;
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (cap_cnt_q == CAP_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cap_cnt_q == '0) begin
                    // Only the wait for the first result is bounded; later gaps are tolerated.
                    if (tmo_cnt_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            proc_reset_q <= 1'b1;
            opcode_q     <= '0;
            constant_q   <= '0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
            n_q          <= '0;
            feed_cnt_q   <= '0;
            cap_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opd_q[i] <= '0;
            end
            for (int i = 0; i < ROWS; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            proc_reset_q <= proc_reset_d;
            opcode_q     <= opcode_d;
            constant_q   <= constant_d;
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
            n_q          <= n_d;
            feed_cnt_q   <= feed_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            opd_q        <= opd_d;
            res_q        <= res_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign proc_reset = proc_reset_q;
    assign opcode     = opcode_q;
    assign constant   = constant_q;
    assign data       = data_q;
    assign data_ready = data_ready_q;
    assign rd_data    = res_q[rd_addr];

endmodule

// File: tb/tb_matrix_host_driver.sv
// Bench for matrix_host_driver: behavioural processor model, table of transactions, scoreboard of expected result rows.
module tb_matrix_host_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [3:0]  op_in;
    logic [31:0] const_in;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy, done, err, proc_reset;
    logic [3:0]  opcode;
    logic [31:0] constant, data;
    logic        data_ready;
    logic [31:0] out = '0;
    logic        out_valid = 1'b0;

    matrix_host_driver #(.WIDTH(32), .ROWS(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .op_in(op_in), .const_in(const_in), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .proc_reset(proc_reset), .opcode(opcode),
        .constant(constant), .data(data), .data_ready(data_ready), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int n_of(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1111: return 16;
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] row_fn(input logic [3:0] op, input logic [31:0] c,
                                           input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b1011: return a << 1;
            default: return a ^ b ^ c;
        endcase
    endfunction

    // Processor model: samples on the edge, answers 1 ns later.
    logic [31:0] prow [16];
    logic [31:0] pres [8];
    int          pcnt = 0;
    int          slot = 0;
    bit          pending = 0, emitting = 0;
    bit          gap_mode = 0, hold_off = 0, stray_en = 0;

    always @(posedge clk) begin
        logic        pr, dr;
        logic [31:0] dv, cv;
        logic [3:0]  opv;
        pr = proc_reset; dr = data_ready; dv = data; opv = opcode; cv = constant;
        #1;
        out_valid = 1'b0;
        if (pr) begin
            pcnt = 0; pending = 0; emitting = 0; slot = 0; out = '0;
        end else begin
            if (emitting) slot++;
            else if (pending) begin emitting = 1; slot = 0; pending = 0; end
            if (emitting) begin
                if (slot >= (gap_mode ? 15 : 8)) emitting = 0;
                else if (!gap_mode || (slot % 2 == 0)) begin
                    out_valid = 1'b1;
                    out = pres[gap_mode ? slot / 2 : slot];
                end
            end
            if (dr) begin
                if (stray_en && pcnt == 2) begin out_valid = 1'b1; out = 32'hBAD0_0BAD; end
                if (pcnt < 16) prow[pcnt] = dv;
                pcnt++;
                if (pcnt == n_of(opv)) begin
                    for (int k = 0; k < 8; k++)
                        pres[k] = row_fn(opv, cv, prow[k], (pcnt == 16) ? prow[k+8] : 32'h0);
                    pending = !hold_off;
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] cst;
        int          pat;
        bit          gap;
        bit          hold;
        bit          robust;
        int          exp_n;
        int          exp_done_k;
        int          exp_err_k;
    } vec_t;

    typedef logic [7:0][31:0] row8_t;

    logic [31:0] rows [16];
    row8_t       exp_q [$];

    task automatic load(input int pat);
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0:       rows[i] = (i < 8) ? 32'(i + 1) : 32'h0;
                1:       rows[i] = (i < 8) ? 32'(i) : 32'(100 + i - 8);
                default: rows[i] = $urandom;
            endcase
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = rows[i];
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        logic [31:0] seen [$];
        int pr_cnt = 0, dr_cnt = 0, done_cnt = 0, err_cnt = 0;
        int done_k = -1, err_k = -1, end_k, mism = 0;
        logic busy0 = 1'b0;
        row8_t e;
        gap_mode = v.gap; hold_off = v.hold; stray_en = v.gap;
        if (v.exp_n != 0 && !v.hold) begin
            for (int k = 0; k < 8; k++)
                e[k] = row_fn(v.op, v.cst, rows[k], (v.exp_n == 16) ? rows[k+8] : 32'h0);
            exp_q.push_back(e);
        end
        op_in = v.op; const_in = v.cst; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        end_k = ((v.exp_done_k >= 0) ? v.exp_done_k : v.exp_err_k) + 3;
        for (int k = 0; k <= end_k; k++) begin
            if (k == 0) busy0 = busy;
            if (proc_reset) pr_cnt++;
            if (data_ready) begin dr_cnt++; seen.push_back(data); end
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (err) begin err_cnt++; if (err_k < 0) err_k = k; end
            if (v.robust && k == 4) begin
                wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'hDEAD_BEEF; start = 1'b1; op_in = 4'b0010;
            end
            if (v.robust && k == 5) begin wr_en = 1'b0; start = 1'b0; op_in = v.op; end
            @(posedge clk); #1;
        end
        for (int i = 0; i < seen.size(); i++) if (seen[i] !== rows[i]) mism++;
        check($sformatf("v%0d_done_at", idx), 32'(done_k), 32'(v.exp_done_k));
        check($sformatf("v%0d_err_at", idx), 32'(err_k), 32'(v.exp_err_k));
        check($sformatf("v%0d_done_pulses", idx), 32'(done_cnt), (v.exp_done_k >= 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_err_pulses", idx), 32'(err_cnt), (v.exp_err_k >= 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_proc_reset_cycles", idx), 32'(pr_cnt), (v.exp_n != 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_data_ready_cycles", idx), 32'(dr_cnt), 32'(v.exp_n));
        check($sformatf("v%0d_data_order", idx), 32'(mism), 32'd0);
        check($sformatf("v%0d_busy_after_start", idx), 32'(busy0), (v.exp_n != 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_idle_at_end", idx), 32'(busy), 32'd0);
        if (done_k >= 0) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL v%0d_scoreboard: done seen, no expected result queued", idx);
            end else begin
                e = exp_q.pop_front();
                for (int r = 0; r < 8; r++) begin
                    rd_addr = 3'(r); #1;
                    check($sformatf("v%0d_result_row%0d", idx, r), rd_data, e[r]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs [7];

    initial begin
        int dcnt, ecnt;
        vec_t again;
        vecs[0] = '{4'b1011, 32'h0,         0, 0, 0, 0, 8,  18, -1};
        vecs[1] = '{4'b0010, 32'h0,         1, 0, 0, 0, 16, 26, -1};
        vecs[2] = '{4'b0101, 32'h0,         2, 0, 0, 0, 0,  -1,  0};
        vecs[3] = '{4'b1100, 32'h5,         2, 0, 1, 0, 8,  -1, 73};
        vecs[4] = '{4'b0001, 32'h7,         2, 1, 0, 1, 16, 33, -1};
        vecs[5] = '{4'b1110, 32'h0000_1234, 2, 0, 0, 0, 8,  18, -1};
        vecs[6] = '{4'b0000, 32'h0,         2, 0, 0, 0, 0,  -1,  0};

        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        op_in = '0; const_in = '0; rd_addr = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_constant", constant, 32'd0);
        check("rst_proc_reset", 32'(proc_reset), 32'd1);
        check("rst_rd_data", rd_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("proc_reset_held_until_edge", 32'(proc_reset), 32'd1);
        @(posedge clk); #1;
        check("proc_reset_cleared", 32'(proc_reset), 32'd0);

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].pat);
            run_txn(i, vecs[i]);
        end

        // Reset while row 3 is on the bus.
        gap_mode = 0; hold_off = 0; stray_en = 0;
        load(0);
        op_in = 4'b1011; const_in = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("midfeed_row3_on_bus", data, rows[3]);
        reset_n = 1'b0; #1;
        check("midfeed_proc_reset", 32'(proc_reset), 32'd1);
        check("midfeed_data_ready", 32'(data_ready), 32'd0);
        check("midfeed_busy", 32'(busy), 32'd0);
        rd_addr = 3'd0; #1;
        check("midfeed_results_cleared", rd_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dcnt = 0; ecnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dcnt++;
            if (err) ecnt++;
        end
        check("midfeed_no_done", 32'(dcnt), 32'd0);
        check("midfeed_no_err", 32'(ecnt), 32'd0);
        again = vecs[0];
        load(0);
        run_txn(7, again);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
